vpu_lane_seq: RTL and testbench
===============================

VPU_LANE_SEQ -- requirements
Module: vpu_lane_seq

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: clk in; rst in.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- cmd_valid  in  1  vector command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  operation: 0 add, 1 sub, 2 mul, 3 itf, 4 fti, 5 max, 6 min, 7 ftl.
- cmd_len  in  4  element count minus 1 (1..16 elements).
- stall  in  1  freeze the whole pipeline.
- rd_en  out  1  register-file read strobe.
- rd_addr  out  4  element index to read.
- rd_a  in  16  operand A; registered in the register file, updated only on the cycle after rd_en.
- rd_b  in  16  operand B; same timing as rd_a.
- alu_enable  out  1  lane enable to the 16-bit FP ALU.
- alu_op1  out  16  ALU operand 1.
- alu_op2  out  16  ALU operand 2.
- alu_sel  out  8  one-hot select; bit order follows cmd_op.
- alu_res  in  16  combinational ALU result.
- alu_gt  in  1  ALU compare output.
- wb_valid  out  1  writeback strobe.
- wb_addr  out  4  writeback element index.
- wb_data  out  16  writeback value.
- done  out  1  one-cycle end-of-command pulse.

Function
REQ-003 States SHALL be IDLE, RUN and DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-004 IDLE: when cmd_valid&cmd_ready, SHALL latch cmd_op and cmd_len, clear the element counter, and go to RUN.
REQ-005 RUN: SHALL assert rd_en with rd_addr=counter each non-stalled cycle, incrementing the counter; after issuing element cmd_len, SHALL go to DRAIN.
REQ-006 Stage S1, the cycle after an rd_en: SHALL drive alu_op1=rd_a, alu_op2=rd_b, alu_enable=1, alu_sel=latched op; when not in S1, alu_enable=0, alu_sel=0, alu_op1/alu_op2=0.
REQ-007 At the end of each non-stalled S1 cycle, SHALL register alu_res into wb_data and the S1 index into wb_addr, and set the writeback-valid register.
REQ-008 Latency: with no stall, element i issued at cycle T+i SHALL produce wb_valid at cycle T+i+2; throughput one element per cycle.
REQ-009 DRAIN: SHALL stay until the last element's wb_valid; done SHALL pulse in that same cycle; SHALL return to IDLE the next cycle.
REQ-010 stall=1 SHALL hold every state register, counter and pipeline register, and force rd_en=0 and wb_valid=0; the held writeback SHALL be presented once, when stall falls.
REQ-011 cmd_len=0 SHALL process exactly one element (IDLE→RUN→DRAIN→IDLE, 4 cycles).
REQ-012 Counter SHALL NOT wrap past cmd_len; cmd_len=15 SHALL stop after index 15.
REQ-013 cmd_valid outside IDLE SHALL be ignored with no side effect.

Reset
REQ-014 rst SHALL asynchronously force IDLE, cmd_ready=1 on release, and every other output, counter and pipeline register to 0; reset mid-command SHALL discard in-flight elements with no wb_valid or done.

Configuration
REQ-015 With VPU_CMP_MASK_EN defined:
- SHALL add output cmp_mask[15:0], cleared at command accept.
- Bit i SHALL be set to alu_gt when element i is registered per REQ-007.
- The value SHALL be stable from done until the next accept.
REQ-016 Without VPU_CMP_MASK_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-017 Shared package vpu_pkg SHALL hold the op encodings, the alu_sel bit indices, the element-count width and the state encoding.
REQ-018 Sub-module vpu_op_decode SHALL convert the 3-bit op to the 8-bit one-hot alu_sel; everything else stays flat.

Verification
REQ-019 add, len=3, all rd_a=rd_b=0x3C00 → four wb_valid at cycles T+2..T+5, wb_addr 0..3, wb_data=ALU output (0x4000 with reference ALU), done at T+5.
REQ-020 mul, len=0, rd_a=0x4000, rd_b=0x4200 → alu_sel=0x04, single wb_valid, done same cycle, cmd_ready high 4 cycles after accept.
REQ-021 add, len=7, stall high 3 cycles after element 2 issued → 8 writebacks, addresses 0..7 in order, no duplicates, done delayed by exactly 3 cycles.
REQ-022 cmd_valid held during RUN with a different op → ignored; latched op unchanged, cmd_ready=0 until IDLE.
REQ-023 rst pulsed after element 4 of len=15 → outputs 0 immediately, no done; a fresh command afterwards completes normally.
REQ-024 (VPU_CMP_MASK_EN) max, len=3, alu_gt pattern 1,0,1,1 → cmp_mask=0x000D at done.

Source files
------------

// File: rtl/vpu_pkg.sv
// vpu_pkg: shared definitions for the vector lane sequencer.
// Holds the operation encodings, the one-hot alu_sel bit positions,
// the element-index width and the sequencer state encoding.
package vpu_pkg;

  localparam int ELEM_W = 4;   // element index width (up to 16 elements)
  localparam int DATA_W = 16;  // element data width
  localparam int OP_W   = 3;
  localparam int SEL_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_ITF = 3'd3,
    OP_FTI = 3'd4,
    OP_MAX = 3'd5,
    OP_MIN = 3'd6,
    OP_FTL = 3'd7
  } vpu_op_e;

  // Bit positions inside alu_sel; ordering follows the op encoding.
  localparam int SEL_ADD = 0;
  localparam int SEL_SUB = 1;
  localparam int SEL_MUL = 2;
  localparam int SEL_ITF = 3;
  localparam int SEL_FTI = 4;
  localparam int SEL_MAX = 5;
  localparam int SEL_MIN = 6;
  localparam int SEL_FTL = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vpu_state_e;

endpackage

// File: rtl/vpu_op_decode.sv
// vpu_op_decode: converts the 3-bit vector op into the 8-bit one-hot
// ALU select.
// Ports:
//   op  in  3  operation code (vpu_op_e encoding)
//   sel out 8  one-hot select, bit positions from vpu_pkg SEL_* indices
module vpu_op_decode
  import vpu_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] sel
);

  always_comb begin
    sel = '0;
    case (vpu_op_e'(op))
      OP_ADD:  sel[SEL_ADD] = 1'b1;
      OP_SUB:  sel[SEL_SUB] = 1'b1;
      OP_MUL:  sel[SEL_MUL] = 1'b1;
      OP_ITF:  sel[SEL_ITF] = 1'b1;
      OP_FTI:  sel[SEL_FTI] = 1'b1;
      OP_MAX:  sel[SEL_MAX] = 1'b1;
      OP_MIN:  sel[SEL_MIN] = 1'b1;
      OP_FTL:  sel[SEL_FTL] = 1'b1;
      default: sel = '0;
    endcase
  end

endmodule

// File: rtl/vpu_lane_seq.sv
// vpu_lane_seq: sequences one vector command through a single 16-bit
// FP ALU lane. Elements are read from the register file one per cycle
// (RUN), presented to the ALU the following cycle (S1), and written back
// the cycle after that. DRAIN waits for the last writeback.
// Optional feature: define VPU_CMP_MASK_EN to add cmp_mask, a per-element
// record of alu_gt for the current command.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/ready       command handshake; cmd_op, cmd_len (count-1)
//   stall                 freezes all state; gates rd_en and wb_valid
//   rd_en, rd_addr        register-file read; rd_a/rd_b return next cycle
//   alu_enable/op1/op2/sel  ALU drive during S1; alu_res/alu_gt results
//   wb_valid/addr/data    element writeback
//   cmp_mask              (VPU_CMP_MASK_EN only) alu_gt per element
//   done                  one-cycle pulse with the last writeback
module vpu_lane_seq
  import vpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ELEM_W-1:0] cmd_len,
  input  logic              stall,
  output logic              rd_en,
  output logic [ELEM_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_a,
  input  logic [DATA_W-1:0] rd_b,
  output logic              alu_enable,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_gt,
  output logic              wb_valid,
  output logic [ELEM_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
`ifdef VPU_CMP_MASK_EN
  output logic [15:0]       cmp_mask,
`endif
  output logic              done
);

  vpu_state_e        state_reg;
  logic [OP_W-1:0]   op_reg;
  logic [ELEM_W-1:0] len_reg;
  logic [ELEM_W-1:0] cnt_reg;
  logic              s1_valid_reg;
  logic [ELEM_W-1:0] s1_addr_reg;
  logic              wb_valid_reg;
  logic [ELEM_W-1:0] wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [SEL_W-1:0]  dec_sel;
  logic              done_int;

  vpu_op_decode u_dec (
    .op  (op_reg),
    .sel (dec_sel)
  );

  assign cmd_ready = (state_reg == ST_IDLE);
  assign rd_en     = (state_reg == ST_RUN) && !stall;
  assign rd_addr   = cnt_reg;

  // S1 is simply "an element was issued on the previous active cycle";
  // rd_a/rd_b are valid throughout S1 because the register file only
  // updates after rd_en, which cannot fire again until S1 advances.
  assign alu_enable = s1_valid_reg;
  assign alu_op1    = s1_valid_reg ? rd_a : '0;
  assign alu_op2    = s1_valid_reg ? rd_b : '0;
  assign alu_sel    = s1_valid_reg ? dec_sel : '0;

  // A writeback held across a stall is only shown on the cycle stall
  // drops, so it is seen exactly once.
  assign wb_valid = wb_valid_reg && !stall;
  assign wb_addr  = wb_addr_reg;
  assign wb_data  = wb_data_reg;

  // Addresses within a command are unique, so matching len identifies
  // the final writeback.
  assign done_int = (state_reg == ST_DRAIN) && wb_valid_reg && !stall &&
                    (wb_addr_reg == len_reg);
  assign done     = done_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
    end else if (!stall) begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg    <= cmd_op;
            len_reg   <= cmd_len;
            cnt_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Hold the counter on the last element so it never wraps.
          if (cnt_reg == len_reg) begin
            state_reg <= ST_DRAIN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (done_int) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      s1_valid_reg <= rd_en;
      s1_addr_reg  <= cnt_reg;
      wb_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        wb_addr_reg <= s1_addr_reg;
        wb_data_reg <= alu_res;
      end
    end
  end

`ifdef VPU_CMP_MASK_EN
  logic [15:0] cmp_mask_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_mask_reg <= '0;
    end else if (!stall) begin
      if (state_reg == ST_IDLE && cmd_valid) begin
        cmp_mask_reg <= '0;
      end else if (s1_valid_reg) begin
        cmp_mask_reg[s1_addr_reg] <= alu_gt;
      end
    end
  end

  assign cmp_mask = cmp_mask_reg;
`else
  logic unused_alu_gt;
  assign unused_alu_gt = alu_gt;
`endif

endmodule

// File: tb/tb_vpu_lane_seq.sv
module tb_vpu_lane_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic        stall;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic        alu_enable;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [7:0]  alu_sel;
  logic [15:0] alu_res;
  logic        alu_gt;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        done;
`ifdef VPU_CMP_MASK_EN
  logic [15:0] cmp_mask;
`endif

  int total = 0;
  int bad   = 0;

  vpu_lane_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .stall      (stall),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .alu_enable (alu_enable),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_sel    (alu_sel),
    .alu_res    (alu_res),
    .alu_gt     (alu_gt),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
`ifdef VPU_CMP_MASK_EN
    .cmp_mask   (cmp_mask),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  // Register-file model: operands appear the cycle after rd_en.
  logic [15:0] ra [16];
  logic [15:0] rb [16];
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      rd_a <= ra[rd_addr];
      rd_b <= rb[rd_addr];
    end
  end

  // Stand-in ALU: asymmetric in its operands and dependent on the select,
  // so swapped operands or a wrong op show up in wb_data.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] s);
    return (a * 16'd3) ^ b ^ {8'h00, s};
  endfunction

  assign alu_res = alu_f(alu_op1, alu_op2, alu_sel);
  assign alu_gt  = (alu_op1 > alu_op2);

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_t;
  wb_t sb_q[$];
  wb_t sb_e;

  // Scoreboard consumer: every visible writeback must match the head.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected addr=%0d data=%h (no writeback expected)", wb_addr, wb_data);
      end else begin
        sb_e = sb_q.pop_front();
        if (wb_addr !== sb_e.addr || wb_data !== sb_e.data) begin
          bad++;
          $display("FAIL wb_data got addr=%0d data=%h exp addr=%0d data=%h",
                   wb_addr, wb_data, sb_e.addr, sb_e.data);
        end
      end
    end
    if (stall === 1'b1) begin
      total++;
      if (wb_valid !== 1'b0 || rd_en !== 1'b0) begin
        bad++;
        $display("FAIL stall_gate got wb_valid=%b rd_en=%b exp 0 0", wb_valid, rd_en);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({rd_en, wb_valid, done, alu_enable, alu_sel, alu_op1, alu_op2,
         wb_addr, wb_data, rd_addr} !== '0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s got rd_en=%b wb_valid=%b done=%b alu_en=%b sel=%h op1=%h wb_data=%h rd_addr=%0d ready=%b exp all 0, ready=1",
               name, rd_en, wb_valid, done, alu_enable, alu_sel, alu_op1, wb_data, rd_addr, cmd_ready);
    end
  endtask

  // Issue one command and follow it to done. The stall window is given as
  // cycle offsets from the first RUN cycle (T). done is expected at
  // T + len + 2 + stall cycles, and the sequencer back in IDLE next cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] len,
                         input int s_from, input int s_len, input bit noise,
                         input string name);
    int  k;
    int  exp_k;
    bit  seen;
    logic [7:0] exp_sel;
    exp_sel = 8'd1 << op;
    exp_k   = int'(len) + 2 + s_len;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      step;
      k++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_wait got cmd_ready=%b exp 1", name, cmd_ready);
    end
    for (int i = 0; i <= int'(len); i++) begin
      sb_q.push_back('{addr: i[3:0], data: alu_f(ra[i], rb[i], exp_sel)});
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    step;
    if (noise) cmd_op = op ^ 3'd3;
    else       cmd_valid = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 80 && !seen; k++) begin
      stall = (k >= s_from) && (k < s_from + s_len);
      @(negedge clk);
      total++;
      if (alu_enable === 1'b1) begin
        if (alu_sel !== exp_sel) begin
          bad++;
          $display("FAIL %s_alu_sel cyc=%0d got=%h exp=%h", name, k, alu_sel, exp_sel);
        end
      end else if ({alu_sel, alu_op1, alu_op2} !== '0) begin
        bad++;
        $display("FAIL %s_alu_idle cyc=%0d got sel=%h op1=%h op2=%h exp 0", name, k, alu_sel, alu_op1, alu_op2);
      end
      if (noise) begin
        total++;
        if (cmd_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s_busy_ready cyc=%0d got=%b exp=0", name, k, cmd_ready);
        end
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        total++;
        if (k != exp_k) begin
          bad++;
          $display("FAIL %s_done_cycle got=%0d exp=%0d", name, k, exp_k);
        end
      end
      @(posedge clk);
      #1;
    end
    stall     = 1'b0;
    cmd_valid = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done_timeout got no done exp done at %0d", name, exp_k);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_after got=%b exp=1", name, cmd_ready);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_wb got=%0d pending exp=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic fill_random;
    for (int i = 0; i < 16; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    check_outputs_zero("reset_hold");
    step;
    step;
    rst = 1'b0;
    step;
    check_outputs_zero("reset_release");
  endtask

  task automatic test_add_basic;
    for (int i = 0; i < 16; i++) begin
      ra[i] = 16'h3C00;
      rb[i] = 16'h3C00;
    end
    run_cmd(3'd0, 4'd3, 99, 0, 1'b0, "add_len3");
  endtask

  task automatic test_mul_single;
    fill_random;
    ra[0] = 16'h4000;
    rb[0] = 16'h4200;
    run_cmd(3'd2, 4'd0, 99, 0, 1'b0, "mul_len0");
  endtask

  task automatic test_stall;
    fill_random;
    run_cmd(3'd0, 4'd7, 3, 3, 1'b0, "add_stall");
  endtask

  task automatic test_ignore_cmd;
    fill_random;
    run_cmd(3'd1, 4'd5, 99, 0, 1'b1, "sub_noise");
  endtask

  task automatic test_len_max;
    fill_random;
    run_cmd(3'd6, 4'd15, 7, 2, 1'b0, "min_len15");
  endtask

  task automatic test_reset_mid;
    fill_random;
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back('{addr: i[3:0], data: alu_f(ra[i], rb[i], 8'h01)});
    end
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_len   = 4'd15;
    step;
    cmd_valid = 1'b0;
    repeat (4) step;
    total++;
    if (rd_en !== 1'b1 || rd_addr !== 4'd4) begin
      bad++;
      $display("FAIL rst_mid_issue got rd_en=%b rd_addr=%0d exp 1 4", rd_en, rd_addr);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check_outputs_zero("rst_mid_now");
    step;
    step;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL rst_mid_quiet cyc=%0d got done=%b ready=%b exp 0 1", k, done, cmd_ready);
      end
    end
    step;
    fill_random;
    run_cmd(3'd0, 4'd4, 99, 0, 1'b0, "after_rst");
  endtask

`ifdef VPU_CMP_MASK_EN
  task automatic test_cmp_mask;
    fill_random;
    ra[0] = 16'h0005; rb[0] = 16'h0003;
    ra[1] = 16'h0002; rb[1] = 16'h0007;
    ra[2] = 16'h0009; rb[2] = 16'h0001;
    ra[3] = 16'h8000; rb[3] = 16'h7FFF;
    run_cmd(3'd5, 4'd3, 99, 0, 1'b0, "max_mask");
    total++;
    if (cmp_mask !== 16'h000D) begin
      bad++;
      $display("FAIL cmp_mask got=%h exp=000d", cmp_mask);
    end
    step;
    total++;
    if (cmp_mask !== 16'h000D) begin
      bad++;
      $display("FAIL cmp_mask_hold got=%h exp=000d", cmp_mask);
    end
    ra[0] = 16'h0001; rb[0] = 16'h0002;
    run_cmd(3'd5, 4'd0, 99, 0, 1'b0, "max_mask_clr");
    total++;
    if (cmp_mask !== 16'h0000) begin
      bad++;
      $display("FAIL cmp_mask_clear got=%h exp=0000", cmp_mask);
    end
  endtask
`endif

  task automatic test_back_to_back;
    fill_random;
    run_cmd(3'd7, 4'd2, 99, 0, 1'b0, "b2b_a");
    run_cmd(3'd4, 4'd9, 1, 1, 1'b0, "b2b_b");
    run_cmd(3'd3, 4'd0, 1, 2, 1'b0, "b2b_c");
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_len   = 4'd0;
    stall     = 1'b0;
    rd_a      = 16'h0000;
    rd_b      = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      ra[i] = 16'h0000;
      rb[i] = 16'h0000;
    end
    test_reset;
    test_add_basic;
    test_mul_single;
    test_stall;
    test_ignore_cmd;
    test_len_max;
    test_reset_mid;
`ifdef VPU_CMP_MASK_EN
    test_cmp_mask;
`endif
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
